// File: rtl/lane_pkg.sv
`default_nettype none
// ============================================================================
// Package : lane_pkg
// Brief   : Shared encodings for the lane transit timer: FSM state codes,
//           E-pass reader codes and fault codes.
// Rev     : 1.0  initial release
// ============================================================================
package lane_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_TIMING     = 3'd1;
  localparam logic [2:0] ST_WAIT_CLEAR = 3'd2;
  localparam logic [2:0] ST_REPORT     = 3'd3;
  localparam logic [2:0] ST_FAULT      = 3'd4;

  // E-pass reader codes; 2'b11 is reserved and treated as no code
  localparam logic [1:0] EPASS_NONE = 2'b00;
  localparam logic [1:0] EPASS_REJ  = 2'b01;
  localparam logic [1:0] EPASS_PAID = 2'b10;

  // Fault codes reported on fault_code
  localparam logic [1:0] FLT_TIMEOUT = 2'b01;
  localparam logic [1:0] FLT_ORDER   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : ms_tick_gen
// Brief  : Millisecond prescaler. Counts 0..DIV-1 while enabled and emits a
//          one-cycle tick on the wrap cycle. A synchronous clear restarts the
//          count and suppresses that cycle's tick.
// Rev    : 1.0  initial release
// ============================================================================
module ms_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Prescaler: clear wins over counting, wraps at DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && !i_clr && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/lane_transit_timer.sv
`default_nettype none
// ============================================================================
// Module : lane_transit_timer
// Brief  : Times a vehicle across NUM_SENSORS in-lane presence sensors,
//          reporting per-segment transit times in ms, and opens the barrier
//          when a paid E-pass code is latched for the current vehicle.
// Config : LTT_DEBOUNCE_EN - when defined, each synchronised sensor level is
//          debounced over DEBOUNCE_CYC consecutive cycles.
// Rev    : 1.0  initial release
// ============================================================================
module lane_transit_timer
  import lane_pkg::*;
#(
  parameter int SYS_FREQ     = 50000000,
  parameter int NUM_SENSORS  = 3,
  parameter int WIDTH_MS     = 16,
  parameter int TIMEOUT_MS   = 5000,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [NUM_SENSORS-1:0]              sensor,
  input  logic [1:0]                          valid_Epass,
  output logic [(NUM_SENSORS-1)*WIDTH_MS-1:0] seg_ms,
  output logic                                done,
  output logic                                fault,
  output logic [1:0]                          fault_code,
  output logic                                paid,
  output logic                                denied,
  output logic                                barrier,
  output logic                                busy
);

  localparam int                  IDXW       = $clog2(NUM_SENSORS);
  localparam logic [IDXW-1:0]     C_LAST_IDX = IDXW'(NUM_SENSORS - 1);
  localparam logic [WIDTH_MS-1:0] C_TIMEOUT  = WIDTH_MS'(TIMEOUT_MS);

  logic [NUM_SENSORS-1:0]              w_lvl;
  logic [NUM_SENSORS-1:0]              r_lvl_d;
  logic [NUM_SENSORS-1:0]              w_rise;
  logic [2:0]                          r_state;
  logic [2:0]                          w_nstate;
  logic [IDXW-1:0]                     r_idx;
  logic [WIDTH_MS-1:0]                 r_ms;
  logic [(NUM_SENSORS-1)*WIDTH_MS-1:0] r_seg;
  logic                                r_fault;
  logic [1:0]                          r_fcode;
  logic                                r_paid;
  logic                                r_denied;
  logic                                r_barrier;
  logic [1:0]                          r_ep_s1;
  logic [1:0]                          r_ep_s2;
  logic                                w_exp;
  logic                                w_ooo;
  logic                                w_entry;
  logic                                w_cap;
  logic                                w_tick;
  logic                                w_busy;
  logic                                w_all_low;
  logic                                w_ep_take;
  logic                                w_paid_nxt;
  logic                                w_denied_nxt;

  // A zero debounce length is meaningless; legal configurations never build this
  if (DEBOUNCE_CYC < 1) begin : g_db_len_illegal
  end

  // Per-sensor 2-flop synchroniser, optionally followed by a debounce filter
  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
    logic [1:0] r_sync;

    // Synchroniser chain for the raw sensor input
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[0], sensor[gi]};
    end

`ifdef LTT_DEBOUNCE_EN
    localparam int            DBW     = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DBW-1:0] C_DB_LAST = DBW'(DEBOUNCE_CYC - 1);
    logic           r_filt;
    logic [DBW-1:0] r_db_cnt;

    // Filtered level follows only after DEBOUNCE_CYC cycles at the new level
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_filt   <= 1'b0;
        r_db_cnt <= '0;
      end else if (r_sync[1] == r_filt) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == C_DB_LAST) begin
        r_filt   <= r_sync[1];
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
    end

    assign w_lvl[gi] = r_filt;
`else
    assign w_lvl[gi] = r_sync[1];
`endif
  end

  assign w_rise    = w_lvl & ~r_lvl_d;
  assign w_all_low = ~|w_lvl;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_entry   = enable && (r_state == ST_IDLE) && w_rise[0];

  // Classify this cycle's rises against the sensor we are waiting for
  always_comb begin
    w_exp = 1'b0;
    w_ooo = 1'b0;
    for (int j = 1; j < NUM_SENSORS; j++) begin
      if (IDXW'(j) == r_idx)     w_exp = w_exp | w_rise[j];
      else if (IDXW'(j) > r_idx) w_ooo = w_ooo | w_rise[j];
    end
  end

  assign w_cap = enable && (r_state == ST_TIMING) && w_exp && !w_ooo;

  ms_tick_gen #(
    .DIV (SYS_FREQ / 1000)
  ) u_tick (
    .clk    (clk),
    .rst    (reset),
    .i_en   (w_busy),
    .i_clr  (w_entry || w_cap),
    .o_tick (w_tick)
  );

  // Next-state decode; enable low overrides everything back to IDLE
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:       if (w_entry) w_nstate = ST_TIMING;
      ST_TIMING: begin
        if (w_ooo)                   w_nstate = ST_FAULT;
        else if (w_exp) begin
          if (r_idx == C_LAST_IDX)   w_nstate = ST_WAIT_CLEAR;
        end
        else if (r_ms == C_TIMEOUT)  w_nstate = ST_FAULT;
      end
      ST_WAIT_CLEAR: if (w_all_low) w_nstate = ST_REPORT;
      ST_REPORT:     w_nstate = ST_IDLE;
      ST_FAULT:      if (w_all_low) w_nstate = ST_IDLE;
      default:       w_nstate = ST_IDLE;
    endcase
    if (!enable) w_nstate = ST_IDLE;
  end

  // E-pass latch: first code seen in a non-fault busy state wins until next entry
  assign w_ep_take = ((r_state == ST_TIMING) || (r_state == ST_WAIT_CLEAR) ||
                      (r_state == ST_REPORT)) && !r_paid && !r_denied &&
                     (r_ep_s2 != EPASS_NONE);
  assign w_paid_nxt   = w_entry ? 1'b0 : (r_paid   | (w_ep_take && (r_ep_s2 == EPASS_PAID)));
  assign w_denied_nxt = w_entry ? 1'b0 : (r_denied | (w_ep_take && (r_ep_s2 == EPASS_REJ)));

  // Main sequencer: state, ms counter, segment capture, faults and E-pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_lvl_d   <= '0;
      r_idx     <= '0;
      r_ms      <= '0;
      r_seg     <= '0;
      r_fault   <= 1'b0;
      r_fcode   <= '0;
      r_paid    <= 1'b0;
      r_denied  <= 1'b0;
      r_barrier <= 1'b0;
      r_ep_s1   <= '0;
      r_ep_s2   <= '0;
    end else begin
      r_state   <= w_nstate;
      r_lvl_d   <= w_lvl;
      r_ep_s1   <= valid_Epass;
      r_ep_s2   <= r_ep_s1;
      r_paid    <= w_paid_nxt;
      r_denied  <= w_denied_nxt;
      r_barrier <= w_paid_nxt &&
                   ((w_nstate == ST_TIMING) || (w_nstate == ST_WAIT_CLEAR));
      if (w_entry) begin
        r_seg   <= '0;
        r_fault <= 1'b0;
        r_fcode <= '0;
        r_ms    <= '0;
        r_idx   <= IDXW'(1);
      end else if (enable && (r_state == ST_TIMING)) begin
        if (w_ooo) begin
          r_fault <= 1'b1;
          r_fcode <= FLT_ORDER;
        end else if (w_exp) begin
          for (int k = 0; k < NUM_SENSORS - 1; k++) begin
            if (r_idx == IDXW'(k + 1)) r_seg[k*WIDTH_MS +: WIDTH_MS] <= r_ms;
          end
          r_ms  <= '0;
          r_idx <= r_idx + IDXW'(1);
        end else if (r_ms == C_TIMEOUT) begin
          r_fault <= 1'b1;
          r_fcode <= FLT_TIMEOUT;
        end else if (w_tick && (r_ms != '1)) begin
          r_ms <= r_ms + WIDTH_MS'(1);
        end
      end
    end
  end

  assign seg_ms     = r_seg;
  assign done       = (r_state == ST_REPORT);
  assign fault      = r_fault;
  assign fault_code = r_fcode;
  assign paid       = r_paid;
  assign denied     = r_denied;
  assign barrier    = r_barrier;
  assign busy       = w_busy;

endmodule
`default_nettype wire
